// File: rtl/demux_scheduler.sv
// Serial-to-demux scheduler: routes accepted serial bits onto a 1-to-4 demux,
// dwelling on each enabled channel for dwell+1 bits per frame.
module demux_scheduler #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         ch_en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               in_valid,
  input  logic               in_data,
  output logic               in_ready,
  output logic               i,
  output logic [1:0]         s,
  output logic               out_valid,
  output logic               frame_done
);

  // Handshake: a bit transfers on any cycle where in_valid && in_ready;
  // in_ready depends only on state, never on in_valid.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state;
  logic [3:0]         mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt;
  logic [1:0]         cur_ch;
  logic               accept;
  logic               last_bit;
  logic [2:0]         nxt;
  logic               wrap;

  function automatic logic [1:0] lowest(input logic [3:0] m);
    lowest = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (m[k]) lowest = 2'(k);
  endfunction

  // {found, channel} of the nearest enabled channel above c
  function automatic logic [2:0] next_higher(input logic [3:0] m, input logic [1:0] c);
    next_higher = 3'b000;
    for (int k = 3; k >= 0; k--)
      if (m[k] && (k > int'(c))) next_higher = {1'b1, 2'(k)};
  endfunction

  assign in_ready = (state == RUN);
  assign accept   = in_valid && in_ready;
  assign last_bit = (cnt == dwell_q);
  assign nxt      = next_higher(mask_q, cur_ch);
  assign wrap     = accept && last_bit && !nxt[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      i          <= 1'b0;
      s          <= 2'b00;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      cnt        <= '0;
      cur_ch     <= 2'd0;
      mask_q     <= 4'd0;
      dwell_q    <= '0;
    end else begin
      out_valid  <= accept;
      i          <= accept & in_data;
      frame_done <= wrap;
      if (accept) s <= cur_ch;

      case (state)
        IDLE: begin
          if (ch_en != 4'd0) begin
            state   <= RUN;
            mask_q  <= ch_en;
            dwell_q <= dwell;
            cur_ch  <= lowest(ch_en);
            cnt     <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (!last_bit) begin
              cnt <= cnt + 1'b1;
            end else begin
              cnt <= '0;
              if (nxt[2]) begin
                cur_ch <= nxt[1:0];
              end else if (ch_en != 4'd0) begin
                // frame boundary: pick up any new mask/dwell without a bubble
                mask_q  <= ch_en;
                dwell_q <= dwell;
                cur_ch  <= lowest(ch_en);
              end else begin
                state  <= IDLE;
                cur_ch <= 2'd0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_scheduler.sv
// Directed bench for demux_scheduler: expected {frame_done, s, i} pushed per
// stimulus bit, popped and compared whenever out_valid is seen.
module tb_demux_scheduler;

  localparam int DWELL_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [3:0]         ch_en;
  logic [DWELL_W-1:0] dwell;
  logic               in_valid;
  logic               in_data;
  logic               in_ready;
  logic               i;
  logic [1:0]         s;
  logic               out_valid;
  logic               frame_done;

  logic [3:0] exp_q[$];
  int vectors = 0;
  int fails   = 0;

  demux_scheduler #(.DWELL_W(DWELL_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_en      (ch_en),
    .dwell      (dwell),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .i          (i),
    .s          (s),
    .out_valid  (out_valid),
    .frame_done (frame_done)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          fails++;
          $display("FAIL unexpected_out: got fd/s/i %0h expected no output at %0t",
                   {frame_done, s, i}, $time);
        end else begin
          check("out_fd_s_i", {4'b0, frame_done, s, i}, {4'b0, exp_q.pop_front()});
        end
      end else begin
        check("gap_fd_i", {6'b0, frame_done, i}, 8'h00);
      end
    end
  end

  // drivers
  task automatic send_bit(input logic d, input logic [1:0] es, input logic efd);
    in_valid = 1'b1;
    in_data  = d;
    check("in_ready_run", {7'b0, in_ready}, 8'h01);
    exp_q.push_back({efd, es, d});
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 1'b0;
  endtask

  task automatic gap();
    in_valid = 1'b0;
    in_data  = 1'b1;
    @(posedge clk); #1;
    in_data  = 1'b0;
  endtask

  task automatic start(input logic [3:0] m, input logic [DWELL_W-1:0] dw);
    ch_en    = m;
    dwell    = dw;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_start", {7'b0, in_ready}, 8'h01);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("reset_outputs", {2'b0, in_ready, out_valid, i, s, frame_done}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    ch_en    = 4'd0;
    dwell    = '0;
    in_valid = 1'b0;
    in_data  = 1'b0;
    #2;
    check("initial_reset", {2'b0, in_ready, out_valid, i, s, frame_done}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // all four channels, one bit each, back-to-back
    start(4'b1111, 4'd0);
    send_bit(1'b1, 2'd0, 1'b0);
    send_bit(1'b0, 2'd1, 1'b0);
    send_bit(1'b1, 2'd2, 1'b0);
    send_bit(1'b1, 2'd3, 1'b1);
    send_bit(1'b0, 2'd0, 1'b0);
    do_reset();

    // channels 1 and 3, two bits each, two frames
    ch_en = 4'd0;
    start(4'b1010, 4'd1);
    send_bit(1'b1, 2'd1, 1'b0);
    send_bit(1'b0, 2'd1, 1'b0);
    send_bit(1'b1, 2'd3, 1'b0);
    send_bit(1'b1, 2'd3, 1'b1);
    send_bit(1'b0, 2'd1, 1'b0);
    send_bit(1'b0, 2'd1, 1'b0);
    send_bit(1'b1, 2'd3, 1'b0);
    send_bit(1'b0, 2'd3, 1'b1);
    do_reset();

    // single channel 2, dwell 3 bits, with input gaps
    start(4'b0100, 4'd2);
    send_bit(1'b1, 2'd2, 1'b0);
    gap();
    send_bit(1'b0, 2'd2, 1'b0);
    gap();
    send_bit(1'b1, 2'd2, 1'b1);
    gap();
    do_reset();

    // mask change mid-frame takes effect only at the boundary
    start(4'b0011, 4'd0);
    send_bit(1'b1, 2'd0, 1'b0);
    ch_en = 4'b1000;
    send_bit(1'b0, 2'd1, 1'b1);
    send_bit(1'b1, 2'd3, 1'b1);
    ch_en = 4'd0;
    do_reset();

    // no channels enabled: stays idle with upstream pushing
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 1'b1;
      @(posedge clk); #1;
      check("in_ready_idle", {7'b0, in_ready}, 8'h00);
    end
    in_valid = 1'b0;
    in_data  = 1'b0;
    start(4'b0001, 4'd0);
    send_bit(1'b1, 2'd0, 1'b1);
    do_reset();

    // reset in the middle of channel 2, then restart from channel 0
    start(4'b0111, 4'd1);
    send_bit(1'b1, 2'd0, 1'b0);
    send_bit(1'b0, 2'd0, 1'b0);
    send_bit(1'b1, 2'd1, 1'b0);
    send_bit(1'b1, 2'd1, 1'b0);
    send_bit(1'b0, 2'd2, 1'b0);
    do_reset();
    start(4'b0111, 4'd1);
    send_bit(1'b1, 2'd0, 1'b0);
    send_bit(1'b1, 2'd0, 1'b0);
    send_bit(1'b0, 2'd1, 1'b0);
    do_reset();

    check("queue_drained", 8'(exp_q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
